// File: rtl/bin_xs3_pkg.sv
// Shared definitions for the serial binary-to-decimal (BCD / excess-3) converter.
//   state_t        : converter FSM states
//   XS3_BIAS       : bias added to a BCD digit to form its excess-3 code
//   DABBLE_THRESH  : digit value at or above which shift-and-add-3 corrects
//   NINE_DIGIT     : single decimal 9, replicated to saturate on overflow
package bin_xs3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        ADJ  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [3:0] XS3_BIAS      = 4'd3;
    localparam logic [3:0] DABBLE_THRESH = 4'd5;
    localparam logic [3:0] NINE_DIGIT    = 4'd9;

endpackage

// File: rtl/dabble_digit.sv
// One double-dabble correction cell: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
//   digit_in  : 4-bit BCD digit before correction
//   digit_out : corrected digit (never above 4'b1100)
module dabble_digit
    import bin_xs3_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= DABBLE_THRESH) ? (digit_in + XS3_BIAS) : digit_in;

endmodule

// File: rtl/bin_to_xs3_serial.sv
// Serial binary-to-decimal converter using shift-and-add-3, one input bit per
// clock, with valid/ready handshakes on both sides. The result is plain BCD or
// excess-3 depending on the mode captured with the input word.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready is high only in IDLE; out_valid is high only in HOLD, where
// dec_out and overflow stay stable until out_ready completes the transfer.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake; bin_in and xs3_mode sampled on transfer
//   bin_in [BIN_W]      : unsigned binary value
//   xs3_mode            : 1 = excess-3 output, 0 = plain BCD
//   out_valid/out_ready : output handshake
//   dec_out [4*DIGITS]  : packed digits, digit 0 in [3:0]
//   overflow            : value did not fit in DIGITS digits (dec_out saturates to 9s)
//   busy                : converting (CONV or ADJ)
//   state_dbg           : current FSM state, for observation only
module bin_to_xs3_serial
    import bin_xs3_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  xs3_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   dec_out,
    output logic                  overflow,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    localparam int CW = $clog2(BIN_W) + 1;
    localparam int DW = 4 * DIGITS;

    generate
        if (BIN_W < 1 || DIGITS < 1) begin : g_bad_params
            $error("bin_to_xs3_serial: BIN_W and DIGITS must both be at least 1");
        end
    endgenerate

    state_t            state, state_nxt;
    logic [BIN_W-1:0]  sh_q;
    logic [DW-1:0]     acc_q;
    logic [DW-1:0]     acc_corr;
    logic [DW-1:0]     adj_src;
    logic [DW-1:0]     adj_val;
    logic [DW-1:0]     dec_q;
    logic              ovf_q;
    logic              mode_q;
    logic [CW-1:0]     cnt_q;
    logic              last_bit;

    assign last_bit = (cnt_q == CW'(BIN_W - 1));

    // On overflow the accumulated digits are meaningless, so saturate to all 9s.
    assign adj_src = ovf_q ? {DIGITS{NINE_DIGIT}} : acc_q;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            dabble_digit u_dabble (
                .digit_in  (acc_q[4*g +: 4]),
                .digit_out (acc_corr[4*g +: 4])
            );
            assign adj_val[4*g +: 4] = mode_q ? (adj_src[4*g +: 4] + XS3_BIAS)
                                              : adj_src[4*g +: 4];
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = ADJ;
                end
            end
            ADJ: begin
                busy      = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: {digits, binary} shift register, sticky overflow, output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            mode_q <= 1'b0;
            cnt_q  <= '0;
            dec_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh_q   <= bin_in;
                        acc_q  <= '0;
                        ovf_q  <= 1'b0;
                        mode_q <= xs3_mode;
                        cnt_q  <= '0;
                    end
                end
                CONV: begin
                    // The top bit of the corrected top digit is about to be
                    // shifted out: that value cannot be represented.
                    if (acc_corr[DW-1]) begin
                        ovf_q <= 1'b1;
                    end
                    acc_q <= {acc_corr[DW-2:0], sh_q[BIN_W-1]};
                    sh_q  <= sh_q << 1;
                    cnt_q <= cnt_q + CW'(1);
                end
                ADJ: begin
                    dec_q <= adj_val;
                end
                default: begin
                end
            endcase
        end
    end

    assign dec_out   = dec_q;
    assign overflow  = ovf_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_bin_to_xs3_serial.sv
// Self-checking bench for bin_to_xs3_serial. Three instances share the input
// side: the main one (BIN_W=8, DIGITS=3), a narrow one (BIN_W=8, DIGITS=2) for
// overflow saturation, and a minimal one (BIN_W=1, DIGITS=1).
module tb_bin_to_xs3_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  bin_in;
    logic        xs3_mode;
    logic        out_ready;

    logic        in_ready, out_valid, overflow, busy;
    logic [11:0] dec_out;
    logic [1:0]  state_dbg;

    logic        d2_in_ready, d2_out_valid, d2_overflow, d2_busy;
    logic [7:0]  d2_dec_out;
    logic [1:0]  d2_state_dbg;

    logic        w1_in_ready, w1_out_valid, w1_overflow, w1_busy;
    logic [3:0]  w1_dec_out;
    logic [1:0]  w1_state_dbg;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  bin;
        logic        mode;
        logic [11:0] exp_dec;
        logic        exp_ovf;
        logic [7:0]  exp_dec2;
        logic        exp_ovf2;
    } vec_t;

    vec_t vecs[10];

    bin_to_xs3_serial #(.BIN_W(8), .DIGITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .bin_in(bin_in), .xs3_mode(xs3_mode), .out_valid(out_valid),
        .out_ready(out_ready), .dec_out(dec_out), .overflow(overflow),
        .busy(busy), .state_dbg(state_dbg)
    );

    bin_to_xs3_serial #(.BIN_W(8), .DIGITS(2)) dut_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d2_in_ready),
        .bin_in(bin_in), .xs3_mode(xs3_mode), .out_valid(d2_out_valid),
        .out_ready(out_ready), .dec_out(d2_dec_out), .overflow(d2_overflow),
        .busy(d2_busy), .state_dbg(d2_state_dbg)
    );

    bin_to_xs3_serial #(.BIN_W(1), .DIGITS(1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w1_in_ready),
        .bin_in(bin_in[0]), .xs3_mode(xs3_mode), .out_valid(w1_out_valid),
        .out_ready(out_ready), .dec_out(w1_dec_out), .overflow(w1_overflow),
        .busy(w1_busy), .state_dbg(w1_state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Decimal digits of v by plain division, saturated to 9s if v does not fit.
    function automatic logic [11:0] model_dec(int v, bit mode, int nd);
        int          lim = 1;
        int          x   = v;
        int          dig;
        logic [11:0] r   = '0;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        for (int i = 0; i < nd; i++) begin
            dig = (v >= lim) ? 9 : (x % 10);
            x   = x / 10;
            if (mode) dig = dig + 3;
            r[4*i +: 4] = dig[3:0];
        end
        return r;
    endfunction

    function automatic logic model_ovf(int v, int nd);
        int lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        return (v >= lim);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Present one word and return 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] v, input logic m);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        bin_in   = v;
        xs3_mode = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bin_in   = 8'($urandom);
        xs3_mode = 1'($urandom);
    endtask

    // Count edges after acceptance until out_valid; also note when the
    // 1-bit instance raised its out_valid.
    task automatic wait_valid(output int lat, output int lat1);
        lat  = 0;
        lat1 = -1;
        while (!out_valid && lat < 100) begin
            if (w1_out_valid && lat1 < 0) lat1 = lat;
            @(posedge clk);
            #1;
            lat++;
        end
        if (w1_out_valid && lat1 < 0) lat1 = lat;
        if (!out_valid) check("result_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic release_out(input int stall);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Convert one word and check all three instances against expectations.
    task automatic run_one(input string tag, input logic [7:0] v, input logic m,
                           input logic [11:0] e_dec, input logic e_ovf,
                           input logic [7:0] e_dec2, input logic e_ovf2);
        int lat, lat1;
        send(v, m);
        wait_valid(lat, lat1);
        check({tag, "_lat"},  lat, 32'd9);
        check({tag, "_dec"},  {20'd0, dec_out}, {20'd0, e_dec});
        check({tag, "_ovf"},  {31'd0, overflow}, {31'd0, e_ovf});
        check({tag, "_dec2"}, {24'd0, d2_dec_out}, {24'd0, e_dec2});
        check({tag, "_ovf2"}, {31'd0, d2_overflow}, {31'd0, e_ovf2});
        check({tag, "_w1lat"}, lat1, 32'd2);
        check({tag, "_w1dec"}, {28'd0, w1_dec_out}, {20'd0, model_dec(int'(v[0]), m, 1)});
        release_out($urandom_range(0, 3));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [11:0] held;
        int          lat, lat1;
        logic [7:0]  rv;
        logic        rm;

        vecs[0] = '{8'd0,   1'b0, 12'h000, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'd0,   1'b1, 12'h333, 1'b0, 8'h33, 1'b0};
        vecs[2] = '{8'd255, 1'b0, 12'h255, 1'b0, 8'h99, 1'b1};
        vecs[3] = '{8'd255, 1'b1, 12'h588, 1'b0, 8'hCC, 1'b1};
        vecs[4] = '{8'd9,   1'b1, 12'h33C, 1'b0, 8'h3C, 1'b0};
        vecs[5] = '{8'd42,  1'b1, 12'h375, 1'b0, 8'h75, 1'b0};
        vecs[6] = '{8'd100, 1'b1, 12'h433, 1'b0, 8'hCC, 1'b1};
        vecs[7] = '{8'd99,  1'b1, 12'h3CC, 1'b0, 8'hCC, 1'b0};
        vecs[8] = '{8'd99,  1'b0, 12'h099, 1'b0, 8'h99, 1'b0};
        vecs[9] = '{8'd100, 1'b0, 12'h100, 1'b0, 8'h99, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        bin_in    = 8'd0;
        xs3_mode  = 1'b0;
        out_ready = 1'b0;

        #12;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_dec_out",   {20'd0, dec_out},   32'd0);
        check("rst_overflow",  {31'd0, overflow},  32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_state",     {30'd0, state_dbg}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of hand-derived vectors
        for (int i = 0; i < 10; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].bin, vecs[i].mode,
                    vecs[i].exp_dec, vecs[i].exp_ovf, vecs[i].exp_dec2, vecs[i].exp_ovf2);
        end

        // Full sweep in both modes against the model
        for (int v = 0; v < 256; v++) begin
            for (int m = 0; m < 2; m++) begin
                run_one($sformatf("sweep_%0d_%0d", v, m), 8'(v), 1'(m),
                        model_dec(v, 1'(m), 3), model_ovf(v, 3),
                        model_dec(v, 1'(m), 2) & 12'h0FF, model_ovf(v, 2));
            end
        end

        // Random words with random output stalls
        for (int i = 0; i < 60; i++) begin
            rv = 8'($urandom_range(0, 255));
            rm = 1'($urandom);
            run_one($sformatf("rand%0d", i), rv, rm,
                    model_dec(int'(rv), rm, 3), model_ovf(int'(rv), 3),
                    model_dec(int'(rv), rm, 2) & 12'h0FF, model_ovf(int'(rv), 2));
        end

        // HOLD with out_ready low: output stable, no second acceptance
        send(8'd123, 1'b0);
        wait_valid(lat, lat1);
        held = dec_out;
        check("hold_first", {20'd0, held}, 32'h123);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bin_in   = 8'($urandom);
            xs3_mode = 1'($urandom);
            @(posedge clk);
            #1;
            check($sformatf("hold_dec_%0d", i),   {20'd0, dec_out},   {20'd0, held});
            check($sformatf("hold_ready_%0d", i), {31'd0, in_ready},  32'd0);
            check($sformatf("hold_valid_%0d", i), {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        bin_in    = 8'd77;
        xs3_mode  = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("xfer_valid", {31'd0, out_valid}, 32'd0);
        check("xfer_ready", {31'd0, in_ready},  32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("second_busy", {31'd0, busy}, 32'd1);
        wait_valid(lat, lat1);
        check("second_lat", lat, 32'd9);
        check("second_dec", {20'd0, dec_out}, 32'h077);
        release_out(0);

        // Reset in the middle of CONV (count = 3)
        send(8'd200, 1'b1);
        for (int i = 0; i < 3; i++) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready",  {31'd0, in_ready},  32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_dec_out",   {20'd0, dec_out},   32'd0);
        check("abort_overflow",  {31'd0, overflow},  32'd0);
        check("abort_busy",      {31'd0, busy},      32'd0);
        check("abort_state",     {30'd0, state_dbg}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("post_abort_idle_%0d", i), {31'd0, out_valid}, 32'd0);
        end
        run_one("after_abort", 8'd42, 1'b1, 12'h375, 1'b0, 8'h75, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
